// File: rtl/dbf_fine_delay_interp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbf_fine_delay_interp_pkg
// Purpose  : Shared widths, zone length and FSM state encoding for the
//            per-channel fine-delay interpolator.
// Revision : 1.0 - initial release
// ============================================================================
package dbf_fine_delay_interp_pkg;

    localparam int INPUT_WD  = 14;                  // signed sample width
    localparam int FRAC_WD   = 4;                   // fraction width F
    localparam int ADDR_WD   = 8;                   // LUT address width
    localparam int ZONE_LEN  = 32;                  // accepted samples per zone
    localparam int FD_OUT_WD = INPUT_WD + FRAC_WD;  // signed output width

    // Sample-in-zone counter width
    localparam int CNT_WD = $clog2(ZONE_LEN);

    // FSM state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    // FLUSH occupies three cycles, counted 0..2
    localparam logic [1:0] c_FLUSH_LAST = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dbf_fine_delay_interp_fd_frac_lut.sv
`default_nettype none
// ============================================================================
// Module   : fd_frac_lut
// Purpose  : Per-focal-zone fraction table. Register array with one
//            synchronous write port and one asynchronous read port. A write
//            and a read of the same address in one cycle return the old
//            value, because the array only updates on the clock edge.
//            Contents are deliberately not reset.
// Ports    : clk        - system clock
//            i_wr_en    - write strobe
//            i_wr_addr  - write address
//            i_wr_data  - fraction to store
//            i_rd_addr  - read address (current focal zone)
//            o_rd_data  - fraction at i_rd_addr
// Revision : 1.0 - initial release
// ============================================================================
module fd_frac_lut
    import dbf_fine_delay_interp_pkg::*;
(
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [ADDR_WD-1:0] i_wr_addr,
    input  logic [FRAC_WD-1:0] i_wr_data,
    input  logic [ADDR_WD-1:0] i_rd_addr,
    output logic [FRAC_WD-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WD;

    logic [FRAC_WD-1:0] r_mem [0:c_DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/dbf_fine_delay_interp.sv
`default_nettype none
// ============================================================================
// Module   : dbf_fine_delay_interp
// Purpose  : DBF fine-delay stage. Applies a fractional-sample delay to the
//            coarse-delayed stream by 2-tap linear interpolation
//                y = x[n]*(2^F - f) + x[n-1]*f
//            with f taken from a per-focal-zone LUT that advances every
//            ZONE_LEN accepted samples. Three-stage pipeline, 1 sample/clk.
// Config   : FD_ZONE_HOLD_EN - when defined, the zone address saturates at
//            the last LUT entry instead of wrapping to 0.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            tx_en           - transmit window, inputs ignored while high
//            start           - level, receive line active
//            fine_din(_valid)- coarse-delayed sample and qualifier
//            lut_addr/lut_wr_en/lut_wdata - fraction LUT write port
//            fine_dout(_valid) - interpolated sample and qualifier
//            busy            - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module dbf_fine_delay_interp
    import dbf_fine_delay_interp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 start,
    input  logic [INPUT_WD-1:0]  fine_din,
    input  logic                 fine_din_valid,
    input  logic [ADDR_WD-1:0]   lut_addr,
    input  logic                 lut_wr_en,
    input  logic [FRAC_WD-1:0]   lut_wdata,
    output logic [FD_OUT_WD-1:0] fine_dout,
    output logic                 fine_dout_valid,
    output logic                 busy
);

    // Unity weight 2^F, one bit wider than the fraction
    localparam logic [FRAC_WD:0] c_ONE = (FRAC_WD+1)'(1 << FRAC_WD);
    localparam logic [CNT_WD-1:0]  c_CNT_LAST  = CNT_WD'(ZONE_LEN - 1);
    localparam logic [ADDR_WD-1:0] c_ZONE_LAST = {ADDR_WD{1'b1}};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_flush_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)                       w_state_nxt = c_RUN;
            c_RUN:   if (!start)                      w_state_nxt = c_FLUSH;
            c_FLUSH: if (r_flush_cnt == c_FLUSH_LAST) w_state_nxt = c_IDLE;
            default:                                  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counts the FLUSH cycles; held at 0 outside FLUSH so it starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_FLUSH)) begin
            r_flush_cnt <= 2'd0;
        end else begin
            r_flush_cnt <= r_flush_cnt + 2'd1;
        end
    end

    assign busy = (r_state != c_IDLE);

    logic w_run_entry;
    logic w_accept;

    assign w_run_entry = (r_state == c_IDLE) && start;
    assign w_accept    = (r_state == c_RUN) && fine_din_valid && !tx_en;

    // ------------------------------------------------------------------
    // Fraction LUT and zone stepping
    // ------------------------------------------------------------------
    logic [ADDR_WD-1:0] r_zone_addr;
    logic [ADDR_WD-1:0] w_zone_nxt;
    logic [CNT_WD-1:0]  r_samp_cnt;
    logic [FRAC_WD-1:0] w_lut_frac;

    fd_frac_lut u_lut (
        .clk       (clk),
        .i_wr_en   (lut_wr_en),
        .i_wr_addr (lut_addr),
        .i_wr_data (lut_wdata),
        .i_rd_addr (r_zone_addr),
        .o_rd_data (w_lut_frac)
    );

`ifdef FD_ZONE_HOLD_EN
    // Last zone's fraction holds for the remainder of the line.
    assign w_zone_nxt = (r_zone_addr == c_ZONE_LAST) ? r_zone_addr
                                                     : r_zone_addr + 1'b1;
`else
    // Natural wrap of the address counter back to zone 0.
    logic w_zone_last_unused;
    assign w_zone_last_unused = (r_zone_addr == c_ZONE_LAST);
    assign w_zone_nxt = r_zone_addr + 1'b1;
`endif

    // History sample x[n-1]; cleared at run start so the first sample of
    // a line interpolates against zero.
    logic signed [INPUT_WD-1:0] r_x1;

    always_ff @(posedge clk) begin
        if (rst || w_run_entry) begin
            r_zone_addr <= '0;
            r_samp_cnt  <= '0;
            r_x1        <= '0;
        end else if (w_accept) begin
            r_x1 <= fine_din;
            if (r_samp_cnt == c_CNT_LAST) begin
                r_samp_cnt  <= '0;
                r_zone_addr <= w_zone_nxt;
            end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: capture current sample, history and fraction
    // ------------------------------------------------------------------
    logic [INPUT_WD-1:0] r_x0;
    logic [INPUT_WD-1:0] r_x1q;
    logic [FRAC_WD-1:0]  r_fq;
    logic                r_v0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0  <= '0;
            r_x1q <= '0;
            r_fq  <= '0;
            r_v0  <= 1'b0;
        end else begin
            r_v0 <= w_accept;
            if (w_accept) begin
                r_x0  <= fine_din;
                r_x1q <= r_x1;
                r_fq  <= w_lut_frac;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: weighted products
    // Each product is bounded by |x|*2^F, so FD_OUT_WD bits hold it
    // exactly. Operands are sign/zero-extended to that width and the
    // low FD_OUT_WD bits of the product are the two's-complement result.
    // ------------------------------------------------------------------
    logic [FRAC_WD:0]   w_wt0;
    logic [FD_OUT_WD-1:0] w_x0_ext;
    logic [FD_OUT_WD-1:0] w_x1_ext;
    logic [FD_OUT_WD-1:0] w_wt0_ext;
    logic [FD_OUT_WD-1:0] w_wt1_ext;
    logic [FD_OUT_WD-1:0] r_p0;
    logic [FD_OUT_WD-1:0] r_p1;
    logic                 r_v1;

    assign w_wt0     = c_ONE - {1'b0, r_fq};
    assign w_x0_ext  = {{(FD_OUT_WD-INPUT_WD){r_x0[INPUT_WD-1]}}, r_x0};
    assign w_x1_ext  = {{(FD_OUT_WD-INPUT_WD){r_x1q[INPUT_WD-1]}}, r_x1q};
    assign w_wt0_ext = {{(FD_OUT_WD-FRAC_WD-1){1'b0}}, w_wt0};
    assign w_wt1_ext = {{(FD_OUT_WD-FRAC_WD){1'b0}}, r_fq};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0 <= '0;
            r_p1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_p0 <= w_x0_ext * w_wt0_ext;
            r_p1 <= w_x1_ext * w_wt1_ext;
            r_v1 <= r_v0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sum. A convex combination cannot exceed |x|*2^F, so the
    // FD_OUT_WD-bit sum never overflows. Output is zeroed on bubbles.
    // ------------------------------------------------------------------
    logic [FD_OUT_WD-1:0] w_sum;
    logic [FD_OUT_WD-1:0] r_dout;
    logic                 r_dout_valid;

    assign w_sum = r_p0 + r_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout       <= r_v1 ? w_sum : '0;
            r_dout_valid <= r_v1;
        end
    end

    assign fine_dout       = r_dout;
    assign fine_dout_valid = r_dout_valid;

endmodule
`default_nettype wire
